// File: rtl/dmem_responder.sv
// Word-organised data-memory responder: one outstanding load/store, fixed access latency,
// error flag on misaligned/out-of-range. Define DMEM_BYTE_STROBE_EN for byte-lane write strobes.
module dmem_responder #(
    parameter int DEPTH_WORDS = 10001,
    parameter int LATENCY     = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [3:0]        req_wstrb,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             state, nextState;
    logic [3:0]         counter;
    logic               reqWrite;
    logic [ADDR_W-1:0]  reqAddr;
    logic [31:0]        reqWdata;
    logic [3:0]         laneEn;
    logic [ADDR_W-1:0]  wordIdx;
    logic [IDX_W-1:0]   memIdx;
    logic               accErr;
    logic               accessNow;
    logic [31:0]        mem [DEPTH_WORDS];

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign wordIdx   = reqAddr >> 2;
    assign memIdx    = wordIdx[IDX_W-1:0];
    assign accErr    = (reqAddr[1:0] != 2'b00) || (wordIdx >= ADDR_W'(DEPTH_WORDS));
    assign accessNow = (state == ACCESS) && (counter == 4'd0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (req_valid)        nextState = ACCESS;
            ACCESS:  if (counter == 4'd0)  nextState = RESP;
            RESP:    if (rsp_ready)        nextState = IDLE;
            default:                       nextState = IDLE;
        endcase
    end

`ifdef DMEM_BYTE_STROBE_EN
    logic [3:0] reqWstrb;
    assign laneEn = reqWstrb;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                       reqWstrb <= 4'h0;
        else if (state == IDLE && req_valid) reqWstrb <= req_wstrb;
    end
`else
    assign laneEn = 4'hF;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            counter   <= 4'd0;
            reqWrite  <= 1'b0;
            reqAddr   <= '0;
            reqWdata  <= 32'h0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                reqWrite <= req_write;
                reqAddr  <= req_addr;
                reqWdata <= req_wdata;
                counter  <= 4'(LATENCY - 1);
            end else if (state == ACCESS && counter != 4'd0) begin
                counter <= counter - 4'd1;
            end

            if (accessNow) begin
                rsp_err   <= accErr;
                rsp_rdata <= (reqWrite || accErr) ? 32'h0 : mem[memIdx];
            end else if (state == RESP && rsp_ready) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= 32'h0;
            end
        end
    end

    // Commit only on the ACCESS exit edge; reset forces IDLE so a pending store never lands.
    always_ff @(posedge clock) begin
        if (accessNow && reqWrite && !accErr) begin
            for (int b = 0; b < 4; b++)
                if (laneEn[b]) mem[memIdx][8*b +: 8] <= reqWdata[8*b +: 8];
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized + directed bench for dmem_responder against an associative-array memory model.
module tb_dmem_responder;
    localparam int DEPTH = 10001;
    localparam int LAT   = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
    logic [3:0]  req_wstrb;
`endif
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic [31:0] refMem [int];
    int nAssert = 0;
    int nFail   = 0;
    int pool [12];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .ADDR_W(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
        .req_wstrb(req_wstrb),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nAssert++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected response from the spec rules: misaligned or beyond DEPTH is an error.
    task automatic predict(input logic w, input logic [31:0] a, output logic e, output logic [31:0] d);
        int idx;
        idx = int'(a >> 2);
        e = (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
        d = 32'h0;
        if (!w && !e) d = refMem.exists(idx) ? refMem[idx] : 32'h0;
    endtask

    task automatic commit(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic e;
        logic [31:0] unused;
        int idx;
        predict(w, a, e, unused);
        idx = int'(a >> 2);
        if (w && !e) begin
            if (!refMem.exists(idx)) refMem[idx] = 32'h0;
            for (int b = 0; b < 4; b++)
                if (s[b]) refMem[idx][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // Called #1 after the accept edge; waits for the response, checks it, completes the handshake.
    task automatic waitRsp(input logic e, input logic [31:0] d, input int hold);
        int lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        chk("latency", lat, LAT);
        for (int h = 0; h < hold; h++) begin
            chk("hold_valid", rsp_valid, 1);
            chk("hold_rdata", rsp_rdata, d);
            chk("hold_ready", req_ready, 0);
            @(posedge clock); #1;
        end
        chk("rsp_err", rsp_err, e);
        chk("rsp_rdata", rsp_rdata, d);
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        chk("post_valid", rsp_valid, 0);
        chk("post_rdata", rsp_rdata, 0);
        chk("post_ready", req_ready, 1);
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
`ifdef DMEM_BYTE_STROBE_EN
        req_wstrb = s;
`else
        if (s != 4'hF) $display("note: strobe %h ignored in full-word build", s);
`endif
    endtask

    task automatic doReq(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int hold);
        logic e;
        logic [31:0] ed;
        logic [3:0] se;
`ifdef DMEM_BYTE_STROBE_EN
        se = s;
`else
        se = 4'hF;
`endif
        predict(w, a, e, ed);
        @(negedge clock);
        drive(w, a, d, se);
        chk("req_ready_idle", req_ready, 1);
        @(posedge clock); #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_write = ~w;
        waitRsp(e, ed, hold);
        commit(w, a, d, se);
    endtask

    initial begin
        logic e;
        logic [31:0] ed;
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 0; req_wdata = 0; rsp_ready = 1'b0;
`ifdef DMEM_BYTE_STROBE_EN
        req_wstrb = 4'hF;
`endif
        repeat (3) @(posedge clock);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        @(negedge clock) reset_n = 1'b1;

        // store/load round trip
        doReq(1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        doReq(0, 32'h10, 32'h0, 4'hF, 0);
        // misaligned accesses leave memory intact
        doReq(1, 32'h13, 32'h55, 4'hF, 1);
        doReq(0, 32'h12, 32'h0, 4'hF, 0);
        doReq(0, 32'h10, 32'h0, 4'hF, 0);
        // range boundary
        doReq(0, 32'(4 * DEPTH), 32'h0, 4'hF, 0);
        doReq(1, 32'(4 * (DEPTH - 1)), 32'h0000CAFE, 4'hF, 0);
        doReq(0, 32'(4 * (DEPTH - 1)), 32'h0, 4'hF, 2);

        // backpressure with a second request waiting
        doReq(1, 32'h14, 32'h600DF00D, 4'hF, 0);
        @(negedge clock);
        drive(0, 32'h10, 32'h0, 4'hF);
        @(posedge clock); #1;
        drive(0, 32'h14, 32'h0, 4'hF);
        waitRsp(1'b0, 32'hDEADBEEF, 5);
        @(posedge clock); #1;
        chk("second_accept", req_ready, 0);
        req_valid = 1'b0;
        waitRsp(1'b0, 32'h600DF00D, 0);

        // reset during ACCESS discards the store
        doReq(1, 32'h20, 32'h0, 4'hF, 0);
        @(negedge clock);
        drive(1, 32'h20, 32'h1234, 4'hF);
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock);
        @(negedge clock) reset_n = 1'b0;
        #1;
        chk("midrst_valid", rsp_valid, 0);
        chk("midrst_ready", req_ready, 1);
        @(negedge clock) reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            chk("midrst_no_rsp", rsp_valid, 0);
        end
        doReq(0, 32'h20, 32'h0, 4'hF, 0);

`ifdef DMEM_BYTE_STROBE_EN
        doReq(1, 32'h30, 32'hAABBCCDD, 4'hF, 0);
        doReq(1, 32'h30, 32'h11223344, 4'b0101, 0);
        predict(0, 32'h30, e, ed);
        chk("strobe_model", ed, 32'hAA22CC44);
        doReq(0, 32'h30, 32'h0, 4'hF, 0);
        doReq(1, 32'h30, 32'hFFFFFFFF, 4'b0000, 0);
        doReq(0, 32'h30, 32'h0, 4'hF, 0);
`endif

        // randomized traffic over a pre-initialised pool of words
        for (int i = 0; i < 8; i++) pool[i] = i;
        pool[8] = 100; pool[9] = 5000; pool[10] = DEPTH - 2; pool[11] = DEPTH - 1;
        for (int i = 0; i < 12; i++) doReq(1, 32'(pool[i] * 4), $urandom, 4'hF, 0);
        for (int i = 0; i < 60; i++) begin
            int kind;
            logic [31:0] a;
            kind = $urandom_range(0, 19);
            a = 32'(pool[$urandom_range(0, 11)] * 4);
            if (kind >= 17)      a = a + 32'($urandom_range(1, 3));
            else if (kind >= 14) a = (kind == 16) ? 32'hFFFFFFFC : 32'((DEPTH + $urandom_range(0, 1000)) * 4);
            doReq(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
